// File: rtl/pi_sim_pkg.sv
// Shared types for the Monte Carlo pi estimator.
// FSM encoding and pipeline drain depth.
package pi_sim_pkg;

  typedef enum logic [2:0] {
    ACCUM,
    DRAIN,
    DIVIDE,
    DONE,
    HOLD
  } state_e;

  localparam int DRAIN_CYCLES = 3;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: quotient = (dividend << (Q_W-1)) / divisor.
// Requires dividend < 2*divisor; one quotient bit per cycle, MSB first.
module seq_divider #(
  parameter int D_W = 20,
  parameter int Q_W = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           abort_i,
  input  logic           start_i,
  input  logic [D_W-1:0] dividend_i,
  input  logic [D_W-1:0] divisor_i,
  output logic           done_o,
  output logic [Q_W-1:0] quotient_o
);

  localparam int CW = $clog2(Q_W + 1);

  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [D_W:0]   rem_q, rem_d;
  logic [D_W-1:0] div_q, div_d;
  logic           bit_q, bit_d;
  logic [Q_W-1:0] quo_q, quo_d;

  logic [D_W+1:0] trial;
  logic [D_W+1:0] diff;
  logic           ge;

  assign trial = {rem_q, bit_q};
  assign diff  = trial - {2'b00, div_q};
  assign ge    = ~diff[D_W+1];

  // Upper dividend bits never yield a quotient bit since dividend < 2*divisor,
  // so the remainder starts at dividend>>1 with dividend[0] still to shift in.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    div_d  = div_q;
    bit_d  = bit_q;
    quo_d  = quo_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CW'(Q_W);
      rem_d  = {2'b00, dividend_i[D_W-1:1]};
      bit_d  = dividend_i[0];
      div_d  = divisor_i;
      quo_d  = '0;
    end else if (busy_q) begin
      rem_d = ge ? diff[D_W:0] : trial[D_W:0];
      quo_d = {quo_q[Q_W-2:0], ge};
      bit_d = 1'b0;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || abort_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      bit_q  <= 1'b0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      quo_q  <= quo_d;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/pi_estimator.sv
// Monte Carlo pi estimator: classifies (x,y) samples against a circle,
// counts a batch and divides 4*inside/total in 3.FRAC_W fixed point.
module pi_estimator
  import pi_sim_pkg::*;
#(
  parameter int RADIUS  = 240,
  parameter int COORD_W = 9,
  parameter int CNT_W   = 20,
  parameter int BATCH   = 1000000,
  parameter int FRAC_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [COORD_W-1:0] sample_x,
  input  logic [COORD_W-1:0] sample_y,
  output logic [CNT_W-1:0]  total_count,
  output logic [CNT_W-1:0]  inside_count,
  output logic [FRAC_W+2:0] estimate,
  output logic              est_valid,
  output logic              busy
);

  localparam int W1   = COORD_W + 1;
  localparam int SQ_W = 2 * COORD_W + 1;
  localparam int Q_W  = FRAC_W + 3;

  localparam logic [W1-1:0]    RAD     = W1'(RADIUS);
  localparam logic [W1-1:0]    LIM     = W1'(2 * RADIUS);
  localparam logic [SQ_W-1:0]  R2      = SQ_W'(RADIUS * RADIUS);
  localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(BATCH);

  state_e state_q, state_d;

  logic [1:0]             drain_q;
  logic [CNT_W-1:0]       accepted_q;
  logic                   s1_valid_q, s2_valid_q;
  logic signed [W1-1:0]   dx_q, dy_q;
  logic [SQ_W-1:0]        sum_q, sum_d;
  logic [SQ_W-1:0]        px, py;
  logic [CNT_W-1:0]       total_q, inside_q;
  logic [Q_W-1:0]         estimate_q;
  logic                   est_valid_q;

  logic           in_square, take, last_take, drain_last;
  logic           div_start, div_done, est_load;
  logic [Q_W-1:0] quotient;

  assign in_square = ({1'b0, sample_x} <= LIM) &&
                     ({1'b0, sample_y} <= LIM);
  assign take      = sample_valid && sample_ready &&
                     in_square && !clear;
  assign last_take = take &&
                     (accepted_q == BATCH_C - CNT_W'(1));
  assign drain_last = (drain_q == 2'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (last_take)  state_d = DRAIN;
        DRAIN:   if (drain_last) state_d = DIVIDE;
        DIVIDE:  if (div_done)   state_d = DONE;
        DONE:                    state_d = HOLD;
        HOLD:                    state_d = HOLD;
        default:                 state_d = ACCUM;
      endcase
    end
  end

  always_comb begin
    sample_ready = (state_q == ACCUM) && (accepted_q < BATCH_C);
    busy         = (state_q == DRAIN) || (state_q == DIVIDE);
    div_start    = (state_q == DRAIN) && drain_last && !clear;
    est_load     = (state_q == DONE) && !clear;
  end

  assign px    = SQ_W'(dx_q) * SQ_W'(dx_q);
  assign py    = SQ_W'(dy_q) * SQ_W'(dy_q);
  assign sum_d = px + py;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      accepted_q <= '0;
      drain_q    <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      sum_q      <= '0;
      total_q    <= '0;
      inside_q   <= '0;
    end else begin
      s1_valid_q <= take;
      if (take) begin
        accepted_q <= accepted_q + CNT_W'(1);
        dx_q <= $signed({1'b0, sample_x} - RAD);
        dy_q <= $signed({1'b0, sample_y} - RAD);
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) sum_q <= sum_d;
      if (s2_valid_q) begin
        total_q <= total_q + CNT_W'(1);
        if (sum_q <= R2) inside_q <= inside_q + CNT_W'(1);
      end
      drain_q <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
    end
  end

  // clear leaves the last estimate visible; only reset wipes it
  always_ff @(posedge clk) begin
    if (reset) begin
      estimate_q  <= '0;
      est_valid_q <= 1'b0;
    end else begin
      est_valid_q <= est_load;
      if (est_load) estimate_q <= quotient;
    end
  end

  seq_divider #(
    .D_W (CNT_W),
    .Q_W (Q_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .abort_i    (clear),
    .start_i    (div_start),
    .dividend_i (inside_q),
    .divisor_i  (total_q),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  assign total_count  = total_q;
  assign inside_count = inside_q;
  assign estimate     = estimate_q;
  assign est_valid    = est_valid_q;

endmodule

// File: tb/tb_pi_estimator.sv
// Bench for pi_estimator: directed and random batches checked
// against an arithmetic model of the circle test and the division.
module tb_pi_estimator;

  localparam int RADIUS  = 4;
  localparam int COORD_W = 9;
  localparam int CNT_W   = 20;
  localparam int BATCH   = 4;
  localparam int FRAC_W  = 12;
  localparam int EW      = FRAC_W + 3;
  localparam int LAT     = 20;

  logic               clk = 1'b0;
  logic               reset, clear, sample_valid, sample_ready;
  logic [COORD_W-1:0] sample_x, sample_y;
  logic [CNT_W-1:0]   total_count, inside_count;
  logic [EW-1:0]      estimate;
  logic               est_valid, busy;

  int n_cmp = 0;
  int n_err = 0;
  int m_tot, m_in;
  int exp_prev;

  always #5 clk = ~clk;

  pi_estimator #(
    .RADIUS  (RADIUS),
    .COORD_W (COORD_W),
    .CNT_W   (CNT_W),
    .BATCH   (BATCH),
    .FRAC_W  (FRAC_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .total_count  (total_count),
    .inside_count (inside_count),
    .estimate     (estimate),
    .est_valid    (est_valid),
    .busy         (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_est();
    longint n;
    if (m_tot == 0) return 0;
    n = longint'(m_in) * (longint'(1) << (FRAC_W + 2));
    return int'(n / m_tot);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y);
    int t;
    int d2;
    sample_x = COORD_W'(x);
    sample_y = COORD_W'(y);
    sample_valid = 1'b1;
    t = 0;
    while (!sample_ready && t < 50) begin
      tick();
      t++;
    end
    if (!sample_ready) begin
      chk("send.ready", 32'(sample_ready), 1);
      sample_valid = 1'b0;
    end else begin
      tick();
      sample_valid = 1'b0;
      if (x <= 2 * RADIUS && y <= 2 * RADIUS) begin
        m_tot++;
        d2 = (x - RADIUS) * (x - RADIUS) +
             (y - RADIUS) * (y - RADIUS);
        if (d2 <= RADIUS * RADIUS) m_in++;
      end
    end
  endtask

  task automatic finish_batch(input string tag);
    int lat, rdy, bsy;
    lat = 0;
    rdy = 0;
    bsy = 0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      tick();
      if (sample_ready) rdy++;
      if (busy) bsy++;
      if (est_valid) lat = k;
    end
    chk({tag, ".lat"}, lat, LAT);
    chk({tag, ".busy"}, bsy, LAT - 2);
    chk({tag, ".ready"}, rdy, 0);
    chk({tag, ".total"}, 32'(total_count), m_tot);
    chk({tag, ".inside"}, 32'(inside_count), m_in);
    chk({tag, ".est"}, 32'(estimate), exp_est());
    exp_prev = exp_est();
    tick();
    chk({tag, ".pulse"}, 32'(est_valid), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_tot = 0;
    m_in  = 0;
  endtask

  task automatic rand_batch(input string tag);
    for (int t = 0; t < 200 && m_tot < BATCH; t++)
      send($urandom_range(0, 9), $urandom_range(0, 9));
    finish_batch(tag);
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    clear = 1'b0;
    sample_valid = 1'b0;
    sample_x = '0;
    sample_y = '0;
    m_tot = 0;
    m_in = 0;
    exp_prev = 0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst.total", 32'(total_count), 0);
    chk("rst.inside", 32'(inside_count), 0);
    chk("rst.est", 32'(estimate), 0);
    chk("rst.ev", 32'(est_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.ready", 32'(sample_ready), 1);

    send(4, 4);
    send(0, 0);
    send(8, 4);
    send(4, 0);
    finish_batch("t1");
    chk("t1.est3", 32'(estimate), 32'h3000);

    do_clear();
    chk("clr.keep", 32'(estimate), exp_prev);
    send(9, 0);
    send(4, 4);
    send(0, 9);
    send(0, 0);
    send(8, 4);
    send(4, 0);
    finish_batch("t2");

    do_clear();
    for (int i = 0; i < 4; i++) send(4, 4);
    sample_valid = 1'b1;
    finish_batch("t3a");
    sample_valid = 1'b0;
    chk("t3a.est4", 32'(estimate), 32'h4000);

    do_clear();
    for (int i = 0; i < 4; i++) send(0, 0);
    finish_batch("t3b");

    for (int b = 0; b < 6; b++) begin
      do_clear();
      rand_batch("rnd");
    end

    do_clear();
    sample_x = COORD_W'(4);
    sample_y = COORD_W'(4);
    sample_valid = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sample_valid = 1'b0;
    repeat (4) tick();
    chk("cv.total", 32'(total_count), 0);
    chk("cv.inside", 32'(inside_count), 0);
    chk("cv.ready", 32'(sample_ready), 1);
    rand_batch("cv");

    do_clear();
    for (int i = 0; i < 4; i++) send(4, 0);
    repeat (8) tick();
    chk("md.busy1", 32'(busy), 1);
    do_clear();
    chk("md.busy0", 32'(busy), 0);
    chk("md.total", 32'(total_count), 0);
    chk("md.ready", 32'(sample_ready), 1);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (est_valid) pulses++;
    end
    chk("md.pulses", pulses, 0);
    chk("md.keep", 32'(estimate), exp_prev);
    rand_batch("md");

    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_tot = 0;
    m_in = 0;
    chk("hr.est", 32'(estimate), 0);
    chk("hr.total", 32'(total_count), 0);
    chk("hr.inside", 32'(inside_count), 0);
    chk("hr.busy", 32'(busy), 0);
    chk("hr.ready", 32'(sample_ready), 1);
    rand_batch("hr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
